// File: rtl/fifo182gmii.sv
// Drains a length FIFO and a 16-bit data FIFO into GMII frames: preamble, SFD,
// payload bytes, then an inter-frame gap. Oversize/empty frames are dropped.
module fifo182gmii #(
    parameter logic [3:0]  Gap    = 4'hC,
    parameter logic [15:0] MaxLen = 16'd1518
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [17:0] len_dout,
    input  logic        len_empty,
    output logic        len_rd_en,
    input  logic [17:0] data_dout,
    input  logic        data_empty,
    output logic        data_rd_en,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_er,
    output logic [31:0] tx_frames,
    output logic [15:0] err_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_PRE, S_SFD, S_DATA, S_DROP, S_GAP, S_ABORT
    } state_t;

    state_t      r_state, w_next;
    logic [15:0] r_cnt, w_cnt;
    logic [15:0] r_len, w_len;
    logic [1:0]  r_arm;
    logic        r_tx_en, r_tx_er;
    logic [7:0]  r_txd;
    logic [31:0] r_frames;
    logic [15:0] r_errs;

    logic        w_tx_en, w_tx_er;
    logic [7:0]  w_txd;
    logic        w_len_rd, w_data_rd;
    logic        w_frame_inc, w_err_inc;
    logic [15:0] w_words;
    state_t      w_after;

    assign w_words = {1'b0, r_len[15:1]} + {15'd0, r_len[0]};
    assign w_after = (Gap == 4'd0) ? S_IDLE : S_GAP;

    // The state register leads the GMII pins by one cycle, so payload bytes
    // are picked straight off data_dout and land in the output flops.
    always_comb begin
        w_next      = r_state;
        w_cnt       = r_cnt;
        w_len       = r_len;
        w_tx_en     = 1'b0;
        w_tx_er     = 1'b0;
        w_txd       = 8'h00;
        w_len_rd    = 1'b0;
        w_data_rd   = 1'b0;
        w_frame_inc = 1'b0;
        w_err_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_arm[1] && !len_empty) begin
                    w_len_rd = 1'b1;
                    w_next   = S_LEN;
                end
            end
            S_LEN: begin
                w_len = len_dout[15:0];
                w_cnt = 16'd0;
                if (len_dout[15:0] == 16'd0) begin
                    w_next    = S_IDLE;
                    w_err_inc = 1'b1;
                end else if (len_dout[15:0] > MaxLen) begin
                    w_next    = S_DROP;
                    w_err_inc = 1'b1;
                end else begin
                    w_next = S_PRE;
                end
            end
            S_PRE: begin
                w_tx_en = 1'b1;
                w_txd   = 8'h55;
                if (r_cnt == 16'd6) begin
                    w_next = S_SFD;
                    w_cnt  = 16'd0;
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
            end
            S_SFD: begin
                w_tx_en = 1'b1;
                w_txd   = 8'hD5;
                w_cnt   = 16'd0;
                if (data_empty) begin
                    w_next = S_ABORT;
                end else begin
                    w_data_rd = 1'b1;
                    w_next    = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_en = 1'b1;
                w_txd   = r_cnt[0] ? data_dout[7:0] : data_dout[15:8];
                w_cnt   = r_cnt + 16'd1;
                if (r_cnt == r_len - 16'd1) begin
                    w_frame_inc = 1'b1;
                    w_next      = w_after;
                    w_cnt       = 16'd0;
                end else if (r_cnt[0]) begin
                    // odd byte that is not the last: the next word is needed
                    if (data_empty) begin
                        w_next = S_ABORT;
                        w_cnt  = 16'd0;
                    end else begin
                        w_data_rd = 1'b1;
                    end
                end
            end
            S_ABORT: begin
                w_tx_en   = 1'b1;
                w_tx_er   = 1'b1;
                w_err_inc = 1'b1;
                w_next    = w_after;
                w_cnt     = 16'd0;
            end
            S_DROP: begin
                if (!data_empty) begin
                    w_data_rd = 1'b1;
                    if (r_cnt == w_words - 16'd1) begin
                        w_next = w_after;
                        w_cnt  = 16'd0;
                    end else begin
                        w_cnt = r_cnt + 16'd1;
                    end
                end
            end
            S_GAP: begin
                if (r_cnt == {12'd0, Gap} - 16'd1) begin
                    w_next = S_IDLE;
                    w_cnt  = 16'd0;
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_next = S_IDLE;
                w_cnt  = 16'd0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 16'd0;
            r_len    <= 16'd0;
            r_arm    <= 2'b00;
            r_tx_en  <= 1'b0;
            r_tx_er  <= 1'b0;
            r_txd    <= 8'h00;
            r_frames <= 32'd0;
            r_errs   <= 16'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_len   <= w_len;
            r_arm   <= {r_arm[0], 1'b1};
            r_tx_en <= w_tx_en;
            r_tx_er <= w_tx_er;
            r_txd   <= w_txd;
            if (w_frame_inc) r_frames <= r_frames + 32'd1;
            if (w_err_inc && r_errs != 16'hFFFF) r_errs <= r_errs + 16'd1;
        end
    end

    // r_arm holds off the first length read until two edges after reset release
    assign len_rd_en  = w_len_rd;
    assign data_rd_en = w_data_rd;
    assign gmii_tx_en = r_tx_en;
    assign gmii_tx_er = r_tx_er;
    assign gmii_txd   = r_txd;
    assign tx_frames  = r_frames;
    assign err_count  = r_errs;

endmodule

// File: tb/tb_fifo182gmii.sv
// Directed bench for fifo182gmii: models both standard-mode FIFOs and logs
// every GMII transmit cycle for comparison against hand-built byte streams.
module tb_fifo182gmii;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [17:0] len_dout = '0;
    logic        len_empty;
    logic        len_rd_en;
    logic [17:0] data_dout = '0;
    logic        data_empty;
    logic        data_rd_en;
    logic        gmii_tx_en;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_er;
    logic [31:0] tx_frames;
    logic [15:0] err_count;

    fifo182gmii dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .len_dout(len_dout), .len_empty(len_empty), .len_rd_en(len_rd_en),
        .data_dout(data_dout), .data_empty(data_empty), .data_rd_en(data_rd_en),
        .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd), .gmii_tx_er(gmii_tx_er),
        .tx_frames(tx_frames), .err_count(err_count)
    );

    always #4 sys_clk = ~sys_clk;

    // FIFO models
    logic [15:0] len_mem [0:15];
    logic [15:0] data_mem [0:2047];
    int len_wp = 0, len_rp = 0, data_wp = 0, data_rp = 0;
    int nd_rd = 0, rd_viol = 0;
    assign len_empty  = (len_wp == len_rp);
    assign data_empty = (data_wp == data_rp);

    always @(posedge sys_clk) begin
        if (len_rd_en) begin
            if (len_wp == len_rp) rd_viol <= rd_viol + 1;
            else begin
                len_dout <= {2'b11, len_mem[len_rp % 16]};
                len_rp   <= len_rp + 1;
            end
        end
        if (data_rd_en) begin
            nd_rd <= nd_rd + 1;
            if (data_wp == data_rp) rd_viol <= rd_viol + 1;
            else begin
                data_dout <= {2'b11, data_mem[data_rp % 2048]};
                data_rp   <= data_rp + 1;
            end
        end
    end

    // GMII monitor
    logic [8:0] tx_q[$];
    logic       en_q[$];
    int idle_bad = 0;
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            en_q.push_back(gmii_tx_en);
            if (gmii_tx_en) tx_q.push_back({gmii_tx_er, gmii_txd});
            else if (gmii_tx_er || gmii_txd != 8'h00) idle_bad = idle_bad + 1;
        end
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_len(input int l);
        len_mem[len_wp % 16] = l[15:0];
        len_wp = len_wp + 1;
    endtask

    task automatic push_words(input int n);
        for (int k = 0; k < n; k++) begin
            data_mem[data_wp % 2048] = {8'(2 * k + 1), 8'(2 * k + 2)};
            data_wp = data_wp + 1;
        end
    endtask

    task automatic push_junk(input int n);
        for (int k = 0; k < n; k++) begin
            data_mem[data_wp % 2048] = 16'hA5A5;
            data_wp = data_wp + 1;
        end
    endtask

    task automatic check_frame(input string tag, input int off, input int l);
        logic [8:0] e;
        chk({tag, "_avail"}, (tx_q.size() >= off + 8 + l) ? 1 : 0, 1);
        for (int i = 0; i < 8 + l && off + i < tx_q.size(); i++) begin
            if (i < 7) e = 9'h055;
            else if (i == 7) e = 9'h0D5;
            else e = {1'b0, 8'(i - 7)};
            chk({tag, "_byte"}, {23'd0, tx_q[off + i]}, {23'd0, e});
        end
    endtask

    task automatic do_reset();
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        len_wp  = len_rp;
        data_wp = data_rp;
        tx_q.delete();
        en_q.delete();
        sys_rst = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    int rd0, a, b, c, d;

    initial begin
        // reset state
        #3;
        chk("rst_len_rd", {31'd0, len_rd_en}, 0);
        chk("rst_data_rd", {31'd0, data_rd_en}, 0);
        chk("rst_tx_en", {31'd0, gmii_tx_en}, 0);
        chk("rst_txd", {24'd0, gmii_txd}, 0);
        chk("rst_frames", tx_frames, 0);
        chk("rst_errs", {16'd0, err_count}, 0);

        // L=60, length queued before release: no early length read
        sys_rst = 1'b0;
        @(negedge sys_clk);
        push_len(60);
        push_words(30);
        rd0 = nd_rd;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("arm_edge1", {31'd0, len_rd_en}, 0);
        run(120);
        check_frame("l60", 0, 60);
        chk("l60_len", tx_q.size(), 68);
        chk("l60_reads", nd_rd - rd0, 30);
        chk("l60_frames", tx_frames, 1);
        chk("l60_errs", {16'd0, err_count}, 0);

        // L=61: last low byte read but not sent
        do_reset();
        rd0 = nd_rd;
        push_len(61);
        push_words(31);
        run(120);
        check_frame("l61", 0, 61);
        chk("l61_len", tx_q.size(), 69);
        chk("l61_reads", nd_rd - rd0, 31);
        chk("l61_frames", tx_frames, 1);

        // two back-to-back L=64 frames: Gap+2 idle cycles between
        do_reset();
        push_len(64); push_words(32);
        push_len(64); push_words(32);
        run(250);
        a = -1; b = -1; c = -1; d = -1;
        for (int i = 0; i < en_q.size(); i++) begin
            if (a < 0) begin if (en_q[i]) a = i; end
            else if (b < 0) begin if (!en_q[i]) b = i; end
            else if (c < 0) begin if (en_q[i]) c = i; end
            else if (d < 0) begin if (!en_q[i]) d = i; end
        end
        chk("two_hi1", b - a, 72);
        chk("two_gap", c - b, 14);
        chk("two_hi2", d - c, 72);
        check_frame("two_f2", 72, 64);
        chk("two_frames", tx_frames, 2);

        // L=0, oversize L=2000 drained, then good L=60
        do_reset();
        rd0 = nd_rd;
        push_len(0);
        push_len(2000); push_junk(1000);
        push_len(60);   push_words(30);
        run(1300);
        chk("drop_len", tx_q.size(), 68);
        check_frame("drop_f3", 0, 60);
        chk("drop_reads", nd_rd - rd0, 1030);
        chk("drop_errs", {16'd0, err_count}, 2);
        chk("drop_frames", tx_frames, 1);

        // underrun: L=60 with only 10 words
        do_reset();
        rd0 = nd_rd;
        push_len(60);
        push_words(10);
        run(150);
        chk("und_len", tx_q.size(), 29);
        if (tx_q.size() >= 29) begin
            chk("und_last", {23'd0, tx_q[27]}, 32'h014);
            chk("und_er", {23'd0, tx_q[28]}, 32'h100);
        end
        chk("und_reads", nd_rd - rd0, 10);
        chk("und_errs", {16'd0, err_count}, 1);
        chk("und_frames", tx_frames, 0);

        // reset mid-frame at data byte 30 of the second frame
        do_reset();
        push_len(60); push_words(30);
        push_len(60); push_words(30);
        for (int i = 0; i < 400 && tx_q.size() < 68 + 38; i++) @(negedge sys_clk);
        chk("mid_reached", (tx_q.size() >= 68 + 38) ? 1 : 0, 1);
        chk("mid_pre_frames", tx_frames, 1);
        #2 sys_rst = 1'b0;
        #1;
        chk("mid_tx_en", {31'd0, gmii_tx_en}, 0);
        chk("mid_tx_er", {31'd0, gmii_tx_er}, 0);
        chk("mid_txd", {24'd0, gmii_txd}, 0);
        chk("mid_len_rd", {31'd0, len_rd_en}, 0);
        chk("mid_data_rd", {31'd0, data_rd_en}, 0);
        chk("mid_frames", tx_frames, 0);
        chk("mid_errs", {16'd0, err_count}, 0);
        do_reset();
        push_len(60); push_words(30);
        run(120);
        check_frame("post", 0, 60);
        chk("post_frames", tx_frames, 1);
        chk("post_errs", {16'd0, err_count}, 0);

        chk("idle_clean", idle_bad, 0);
        chk("rd_when_empty", rd_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo182gmii.md
FIFO182GMII -- requirements
Module: fifo182gmii

Interface
REQ-001 Parameter Gap, default 4'hC: number of idle inter-frame cycles inserted after each transmitted frame.
REQ-002 Parameter MaxLen, default 16'd1518: largest accepted frame length in bytes.
REQ-003 sys_clk  in  1  single clock (125 MHz); all logic on its rising edge.
REQ-004 sys_rst  in  1  reset, asynchronous, active-low.
REQ-005 len_dout  in  18  length FIFO read data; [15:0] frame byte count; [17:16] ignored.
REQ-006 len_empty  in  1  length FIFO empty.
REQ-007 len_rd_en  out  1  length FIFO read strobe.
REQ-008 data_dout  in  18  data FIFO read data; [15:8] earlier byte, [7:0] later byte; [17:16] ignored.
REQ-009 data_empty  in  1  data FIFO empty.
REQ-010 data_rd_en  out  1  data FIFO read strobe.
REQ-011 gmii_tx_en  out  1  GMII transmit enable.
REQ-012 gmii_txd  out  8  GMII transmit data.
REQ-013 gmii_tx_er  out  1  GMII transmit error.
REQ-014 tx_frames  out  32  count of frames sent to completion.
REQ-015 err_count  out  16  count of dropped and aborted frames.

Function
REQ-016 Both FIFOs are standard mode: dout is valid the cycle after the rd_en cycle. The block never asserts rd_en while the matching empty is high.
REQ-017 States: IDLE, LEN, PRE, SFD, DATA, DROP, GAP.
REQ-018 IDLE, len_empty=0: one-cycle len_rd_en pulse, then go to LEN.
REQ-019 LEN captures len_dout[15:0] as L.
  - L=0: to IDLE; err_count+1.
  - L>MaxLen: to DROP; err_count+1.
  - Otherwise: to PRE.
REQ-020 PRE: 7 cycles, gmii_tx_en=1, gmii_txd=8'h55.
REQ-021 SFD: 1 cycle, gmii_tx_en=1, gmii_txd=8'hD5; data_rd_en=1 in this cycle for word 0.
REQ-022 DATA: one byte per cycle, gmii_tx_en=1, for L cycles.
  - Byte 2k = word k [15:8]; byte 2k+1 = word k [7:0].
  - For word k+1, data_rd_en pulses in the cycle that outputs byte 2k+1, only when 2k+2 < L.
REQ-023 Odd L: the low byte of the final word is read but not transmitted.
REQ-024 Words read per frame are exactly ceil(L/2).
REQ-025 After the last byte: to GAP; tx_frames+1 (32-bit wrap).
REQ-026 DROP: reads ceil(L/2) words, one per cycle while data_empty=0, stalling while empty; gmii_tx_en=0 throughout; then to GAP.
REQ-027 Underrun in DATA (data_empty=1 in a cycle needing data_rd_en), handling on the next cycle:
  - gmii_tx_en=1, gmii_tx_er=1, gmii_txd=8'h00 for one cycle;
  - err_count+1; no tx_frames increment;
  - the unread remainder of the frame is abandoned; then to GAP.
REQ-028 GAP: gmii_tx_en=0, gmii_txd=0 for exactly Gap cycles, then to IDLE. Gap=0 means go directly to IDLE.
REQ-029 Outside PRE/SFD/DATA and underrun, gmii_tx_en=0, gmii_tx_er=0, gmii_txd=8'h00.
REQ-030 All GMII outputs are registered.
REQ-031 err_count saturates at 16'hFFFF.
REQ-032 L is 16 bits. The byte counter is at least 16 bits with no wrap for L≤MaxLen.
REQ-033 len_empty changing during a frame has no effect until the next IDLE.

Reset
REQ-034 With sys_rst=0, asynchronously and without waiting for a clock, the block shall:
  - force state IDLE;
  - drive len_rd_en, data_rd_en, gmii_tx_en, gmii_tx_er = 0 and gmii_txd = 8'h00;
  - clear tx_frames and err_count to 0.
REQ-035 Reset mid-frame truncates the frame with no tx_er; FIFO contents are not touched.
REQ-036 After sys_rst rises, the first len_rd_en occurs no earlier than the second rising edge.

Verification
REQ-037 L=60, 30 words 16'h0102..: 7x55, D5, then bytes 01,02,03,... for 60 cycles; 30 data_rd_en pulses; tx_frames=1; then 12 idle cycles.
REQ-038 L=61, 31 words: 61 data bytes sent; the low byte of word 30 is not sent; 31 reads; tx_frames=1.
REQ-039 Two frames queued (L=64, L=64): gmii_tx_en low for Gap+2 cycles (GAP plus IDLE/LEN) between the frames; tx_frames=2.
REQ-040 L=0, then L=2000 with 1000 words, then L=60: no transmission for the first two; 1000 words drained; third frame correct; err_count=2, tx_frames=1.
REQ-041 L=60 with only 10 words present: 20 bytes sent, then one cycle tx_en=1/tx_er=1; err_count=1, tx_frames=0.
REQ-042 sys_rst=0 asserted at data byte 30, off-edge: all outputs 0 within the same timestep, counters 0; after release, next frame sent correctly.
